// File: rtl/sisc_dmem_resp.sv
// -----------------------------------------------------------------------------
// sisc_dmem_resp
//
// Data-memory responder for the SISC control unit. A request is sampled in
// IDLE, the block then inserts WAIT wait-state cycles, performs the access on
// the edge entering RESP and pulses ack for exactly one cycle. Out-of-range
// addresses (addr >= DEPTH) never touch the memory; they answer with
// rdata = 0 and err = 1.
//
// Parameters
//   DEPTH  number of 32-bit words stored (at most 65536)
//   WAIT   wait-state cycles inserted before each response (0..15)
//
// Ports
//   clk    system clock, all state changes on its rising edge
//   rst_f  asynchronous active-low reset
//   req    access request, sampled only in IDLE
//   we     1 = write, 0 = read, sampled with req
//   addr   16-bit word address, sampled with req
//   wdata  write data, sampled with req
//   rdata  read data, meaningful only while ack = 1 (0 for writes/errors)
//   ack    one-cycle response pulse (the RESP cycle)
//   busy   high whenever the FSM is not in IDLE
//   err    address-range error flag, meaningful only while ack = 1
// -----------------------------------------------------------------------------
module sisc_dmem_resp #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Counter preload; with WAIT = 0 the counter is never consulted.
    localparam logic [3:0] CNT_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    // Request fields captured at E0 so later input changes are ignored.
    logic        r_we;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;

    logic [31:0] r_mem [DEPTH];

    logic [31:0] r_rdata;
    logic        r_ack;
    logic        r_busy;
    logic        r_err;

    // Access performed on the edge entering RESP.
    logic        w_acc_go;
    logic        w_acc_we;
    logic [15:0] w_acc_addr;
    logic [31:0] w_acc_wdata;
    logic        w_acc_oor;
    logic        w_mem_wr;
    logic [AW-1:0] w_mem_idx;

    logic [31:0] w_rdata_next;
    logic        w_ack_next;
    logic        w_busy_next;
    logic        w_err_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and access decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_acc_go     = 1'b0;
        // Outside IDLE the latched request is what gets executed.
        w_acc_we     = r_we;
        w_acc_addr   = r_addr;
        w_acc_wdata  = r_wdata;

        case (r_state)
            ST_IDLE: begin
                // With WAIT = 0 the access happens on E0 itself, so the
                // live inputs are used directly in that case.
                w_acc_we    = we;
                w_acc_addr  = addr;
                w_acc_wdata = wdata;
                if (req) begin
                    w_cnt_next = CNT_LOAD;
                    if (WAIT == 0) begin
                        w_state_next = ST_RESP;
                        w_acc_go     = 1'b1;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                    w_acc_go     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Full 16-bit compare: no aliasing of high addresses onto memory.
        w_acc_oor = ({1'b0, w_acc_addr} >= 17'(DEPTH));
        w_mem_idx = w_acc_addr[AW-1:0];
        w_mem_wr  = w_acc_go && w_acc_we && !w_acc_oor;

        w_ack_next  = w_acc_go;
        w_err_next  = w_acc_go && w_acc_oor;
        w_busy_next = (w_state_next != ST_IDLE);

        w_rdata_next = r_rdata;
        if (w_acc_go) begin
            if (w_acc_we || w_acc_oor) begin
                w_rdata_next = 32'd0;
            end else begin
                w_rdata_next = r_mem[w_mem_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_we    <= 1'b0;
            r_addr  <= 16'd0;
            r_wdata <= 32'd0;
        end else if (r_state == ST_IDLE && req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Storage. Reset never clears the contents; it is in the sensitivity
    // list only so that a write coinciding with reset is suppressed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            // contents intentionally preserved
        end else if (w_mem_wr) begin
            r_mem[w_mem_idx] <= w_acc_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_rdata <= 32'd0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_rdata <= w_rdata_next;
            r_ack   <= w_ack_next;
            r_busy  <= w_busy_next;
            r_err   <= w_err_next;
        end
    end

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign busy  = r_busy;
    assign err   = r_err;

endmodule
